// File: rtl/button_debounce_multi_if.sv
// button_debounce_multi_if: raw button pins in, debounced levels and event flags out.
interface button_debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button_signal;
    logic [CHANNELS-1:0] pressed_level;
    logic [CHANNELS-1:0] press_flag;
    logic [CHANNELS-1:0] release_flag;
    logic [CHANNELS-1:0] long_flag;
    logic [CHANNELS-1:0] repeat_flag;
    modport master (
        output button_signal,
        input  pressed_level, press_flag, release_flag, long_flag, repeat_flag
    );
    modport slave (
        input  button_signal,
        output pressed_level, press_flag, release_flag, long_flag, repeat_flag
    );
endinterface

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: per-channel synchroniser, counter debounce, press/release,
// long-press and auto-repeat flags for a bank of buttons.
module button_debounce_multi #(
    parameter int CHANNELS          = 4,
    parameter bit INVERT            = 1'b1,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1000,
    parameter int REPEAT_CYCLES     = 200,
    parameter bit REPEAT_ENABLE     = 1'b1
) (
    input logic clock,
    input logic reset,
    button_debounce_multi_if.slave bus
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = LONG_PRESS_CYCLES > 1 ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] L_MAX = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX = RW'(REPEAT_CYCLES - 1);

    logic [CHANNELS-1:0] sync1, sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.button_signal ^ {CHANNELS{INVERT}};
            sync2 <= sync1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DW-1:0] deb;
        logic [HW-1:0] hold;
        logic [RW-1:0] rep;
        logic st, long_done, press_r, release_r, long_r, repeat_r;
        logic accept, held;
        // held excludes the release edge so no long/repeat fires on it
        assign accept = (sync2[c] != st) && (deb == D_MAX);
        assign held   = st && !accept;
        always_ff @(posedge clock) begin
            if (reset) begin
                deb       <= '0;
                hold      <= '0;
                rep       <= '0;
                st        <= 1'b0;
                long_done <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                repeat_r  <= 1'b0;
            end else begin
                deb       <= (sync2[c] == st || accept) ? '0 : deb + 1'b1;
                st        <= accept ? sync2[c] : st;
                press_r   <= accept && !st;
                release_r <= accept && st;
                hold      <= !held ? '0 : (hold == L_MAX ? hold : hold + 1'b1);
                long_r    <= held && !long_done && hold == L_MAX;
                long_done <= held && (long_done || hold == L_MAX);
                rep       <= (!(held && long_done) || rep == R_MAX) ? '0 : rep + 1'b1;
                repeat_r  <= REPEAT_ENABLE && held && long_done && rep == R_MAX;
            end
        end
        assign bus.pressed_level[c] = st;
        assign bus.press_flag[c]    = press_r;
        assign bus.release_flag[c]  = release_r;
        assign bus.long_flag[c]     = long_r;
        assign bus.repeat_flag[c]   = repeat_r;
    end
endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- Multi-channel successor to the single-bit button edge handlers.
- Per channel: 2-flop synchroniser, counter-based debounce, press/release one-cycle flags, long-press detection and optional auto-repeat.
- Sits between raw board button pins and control FSMs / menu logic; one instance serves the whole button bank.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- INVERT, 1, XORed with every raw input; 1 = active-low buttons. After inversion, 1 = pressed.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new level (>=1).
- LONG_PRESS_CYCLES, 1000, hold time from press_flag to long_flag (>=2).
- REPEAT_CYCLES, 200, auto-repeat period after long press (>=1).
- REPEAT_ENABLE, 1, 1 = generate repeat_flag; 0 = repeat_flag tied 0.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- button_signal  input  CHANNELS  raw asynchronous button pins.
- pressed_level  output  CHANNELS  debounced level, 1 = held.
- press_flag  output  CHANNELS  one-cycle pulse on accepted press.
- release_flag  output  CHANNELS  one-cycle pulse on accepted release.
- long_flag  output  CHANNELS  one-cycle pulse, once per press, after LONG_PRESS_CYCLES of holding.
- repeat_flag  output  CHANNELS  one-cycle pulses every REPEAT_CYCLES after long_flag while held.

Behaviour:
- Channels are fully independent; no shared state. Any combination of channels may flag in the same cycle.
- Reset (sampled on the clock edge):
  - Synchroniser flops, debounced state, all counters and all outputs go to 0, i.e. released.
  - A reset asserted mid-press, mid-debounce or mid-repeat aborts the activity.
  - No release_flag is generated by reset.
- Synchroniser: sync1 <= button_signal ^ INVERT; sync2 <= sync1.
- Debounce, per channel:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Any bounce back to the stable value restarts the count.
- Latency: input settled before sampling edge 1 gives the pressed_level change and the flag after edge DEBOUNCE_CYCLES+2. Example: DEBOUNCE_CYCLES=4 gives edge 6. Identical for press and release.
- Flags:
  - press_flag and release_flag are registered and change on the same edge as pressed_level (stable 0->1 / 1->0).
  - Each is high for exactly one cycle.
- Hold timer:
  - Cleared on the press edge; increments each cycle while stable=1.
  - Press accepted on cycle P gives long_flag on cycle P+LONG_PRESS_CYCLES, exactly once per press.
  - The counter then stops counting long-press time; no wrap.
- Repeat (REPEAT_ENABLE=1): repeat_flag on cycles P+LONG_PRESS_CYCLES+n*REPEAT_CYCLES, n=1,2,... while stable=1. A modulo counter is used, so unlimited hold never overflows.
- Release:
  - On the release edge the hold and repeat counters clear.
  - No long_flag or repeat_flag on or after the release cycle.
  - Release before P+LONG_PRESS_CYCLES produces no long_flag.
- Counter widths: $clog2 of the respective parameter, at minimum 1 bit. Hold counter saturates and never wraps.
- A button held through reset deassertion is treated as a new press: press_flag after DEBOUNCE_CYCLES+2 edges counted from the first edge with reset low.

Test Plan:
Common setup: CHANNELS=2, INVERT=1, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8, REPEAT_ENABLE=1.
1. Reset high 3 cycles, button_signal=2'b11 -> all outputs 0 during and after reset; no flags for 50 cycles.
2. button_signal[0] 1->0 before edge 1, held -> pressed_level=2'b01 and press_flag=2'b01 after edge 6; press_flag back to 0 after edge 7.
3. ch0 low 3 cycles, high 1 cycle, then low held -> no flag during bounce; press_flag after edge 6 counted from the final fall.
4. ch1 held; press at cycle P -> long_flag[1] at P+20 only; repeat_flag[1] at P+28, P+36, P+44. Release at P+47 -> release_flag[1] 6 edges later; no repeat_flag afterwards.
5. Both channels fall before the same edge -> press_flag=2'b11 in one cycle. Release ch0 only -> release_flag=2'b01; ch1 long_flag still at its P+20.
6. ch0 held, reset pulsed at P+10 -> all outputs 0 next cycle; after reset low, press_flag re-asserts after 6 edges; long_flag 20 cycles after the new press, none at the old P+20.
